// File: rtl/vram_arb.sv
// Banked video RAM with a strict-priority/round-robin channel arbiter and a power-up clear
// sequencer. Reads return tagged data with a fixed one-cycle latency.
module vram_arb #(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       BANKS          = 4,
  parameter int unsigned       NUM_CH         = 3,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_WORD     = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_CH-1:0]              req_i,
  input  logic [NUM_CH-1:0]              wr_i,
  input  logic [NUM_CH*(DATA_W/4)-1:0]   wr_mask_i,
  input  logic [NUM_CH*ADDR_W-1:0]       addr_i,
  input  logic [NUM_CH*DATA_W-1:0]       wr_data_i,
  output logic [NUM_CH-1:0]              ack_o,
  output logic                           rd_valid_o,
  output logic [$clog2(NUM_CH)-1:0]      rd_ch_o,
  output logic [DATA_W-1:0]              rd_data_o,
  output logic                           busy_o
);

  localparam int unsigned NibW     = DATA_W / 4;
  localparam int unsigned ChW      = $clog2(NUM_CH);
  localparam int unsigned BankSelW = $clog2(BANKS);
  localparam int unsigned BankIdxW = (BankSelW == 0) ? 1 : BankSelW;
  localparam int unsigned LocW     = ADDR_W - BankSelW;
  localparam int unsigned LocDepth = 2 ** LocW;

  typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [ChW-1:0]      rr_q;
  logic [ChW-1:0]      rd_ch_q;
  logic                rd_valid_q;
  logic [BankIdxW-1:0] rd_bank_q;

  logic                gnt_any;
  logic [ChW-1:0]      gnt_ch;
  logic [ChW:0]        cand;

  // Channel 0 wins outright; otherwise scan 1..NUM_CH-1 starting at rr_q.
  always_comb begin
    ack_o   = '0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    if (state_q == StReady && !reset_i) begin
      if (req_i[0]) begin
        gnt_any = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
          cand = {1'b0, rr_q} + (ChW+1)'(i);
          if (cand >= (ChW+1)'(NUM_CH)) cand = cand - (ChW+1)'(NUM_CH - 1);
          if (!gnt_any && req_i[cand[ChW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_ch  = cand[ChW-1:0];
          end
        end
      end
      ack_o[gnt_ch] = gnt_any;
    end
  end

  logic                mem_we;
  logic                mem_re;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NibW-1:0]     mem_mask;
  logic [BankIdxW-1:0] mem_bank;
  logic [LocW-1:0]     mem_loc;

  // Single internal memory port shared by the clear sequencer and the granted channel.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    if (state_q == StClear && !reset_i) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr_q;
      mem_wdata = CLEAR_WORD;
      mem_mask  = '1;
    end else if (gnt_any) begin
      mem_we    = wr_i[gnt_ch];
      mem_re    = !wr_i[gnt_ch];
      mem_addr  = addr_i[gnt_ch*ADDR_W +: ADDR_W];
      mem_wdata = wr_data_i[gnt_ch*DATA_W +: DATA_W];
      mem_mask  = wr_mask_i[gnt_ch*NibW +: NibW];
    end
  end

  if (BankSelW == 0) begin : g_one_bank
    assign mem_bank = '0;
    assign mem_loc  = mem_addr;
  end else begin : g_multi_bank
    assign mem_bank = mem_addr[ADDR_W-1 -: BankSelW];
    assign mem_loc  = mem_addr[LocW-1:0];
  end

  logic [DATA_W-1:0] bank_rd [BANKS];
  logic [DATA_W-1:0] rd_word;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [LocDepth];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (mem_bank == BankIdxW'(b)) begin
        if (mem_we) begin
          for (int n = 0; n < NibW; n++) begin
            if (mem_mask[n]) mem_q[mem_loc][4*n +: 4] <= mem_wdata[4*n +: 4];
          end
        end
        if (mem_re) rd_q <= mem_q[mem_loc];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  if (BankSelW == 0) begin : g_rd_direct
    assign rd_word = bank_rd[0];
  end else begin : g_rd_mux
    assign rd_word = bank_rd[rd_bank_q];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StReset;
      clr_addr_q <= '0;
      rr_q       <= ChW'(1);
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      rd_bank_q  <= '0;
    end else begin
      rd_valid_q <= mem_re;
      if (mem_re) begin
        rd_ch_q   <= gnt_ch;
        rd_bank_q <= mem_bank;
      end
      unique case (state_q)
        StReset: state_q <= CLEAR_ON_RESET ? StClear : StReady;
        StClear: begin
          // Terminate on the last address rather than wrapping into a second pass.
          if (clr_addr_q == '1) state_q <= StReady;
          else                  clr_addr_q <= clr_addr_q + ADDR_W'(1);
        end
        StReady: begin
          if (gnt_any && gnt_ch != '0) begin
            rr_q <= (gnt_ch == ChW'(NUM_CH - 1)) ? ChW'(1) : gnt_ch + ChW'(1);
          end
        end
        default: state_q <= StReset;
      endcase
    end
  end

  assign busy_o     = (state_q != StReady);
  assign rd_valid_o = rd_valid_q;
  assign rd_ch_o    = rd_ch_q;
  assign rd_data_o  = rd_valid_q ? rd_word : '0;

endmodule

// File: doc/vram_arb.md
# vram_arb

Parametrised, banked video RAM with a built-in multi-channel arbiter and a power-up clear sequencer. It is the next generation of the single-port VRAM. It replaces the single address/data port with NUM_CH request/acknowledge channels: channel 0 is video fetch, and the remaining channels are CPU/blitter. It also returns tagged read data with fixed one-cycle latency. Word width, address width and bank count are parameters, so the same block serves simulation (inferred arrays) and ICE40 SPRAM builds.

## Interface
- ADDR_W, 16, word address width; total depth 2^ADDR_W words
- DATA_W, 16, word width; must be a multiple of 4
- BANKS, 4, number of physical banks; power of 2, ≥1; bank = addr[ADDR_W-1 -: log2(BANKS)]
- NUM_CH, 3, request channels; ≥2
- CLEAR_ON_RESET, 1, 1 = fill all words with CLEAR_WORD after reset
- CLEAR_WORD, 0, fill value, DATA_W bits
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_CH  per-channel request
- wr  in  NUM_CH  per-channel write (1) / read (0)
- wr_mask  in  NUM_CH*(DATA_W/4)  per-channel nibble write enables, channel k at slice k
- addr  in  NUM_CH*ADDR_W  per-channel word address
- wr_data  in  NUM_CH*DATA_W  per-channel write data
- ack  out  NUM_CH  one-hot grant; combinational from req, state and rr pointer
- rd_valid  out  1  read data valid
- rd_ch  out  $clog2(NUM_CH)  channel index of returned read
- rd_data  out  DATA_W  read word; forced to 0 when rd_valid=0
- busy  out  1  high while in RESET/CLEAR; no acks are issued

## Operation
- FSM states: RESET → CLEAR (if CLEAR_ON_RESET) → READY. When CLEAR_ON_RESET=0: RESET → READY.
- reset=1 in any state forces RESET on the next edge. clr_addr←0, rr←1, rd_valid←0, rd_ch←0, busy=1, ack=0.
- RESET state: one cycle, then proceeds.
- CLEAR state: writes CLEAR_WORD with a full mask to clr_addr each cycle, then clr_addr++. It leaves for READY after writing address 2^ADDR_W−1, so clear takes exactly 2^ADDR_W cycles. busy=1 and ack=0 throughout.
- READY arbitration, one grant per cycle:
  - If req[0]=1, ack[0]=1. Channel 0 has strict priority.
  - Otherwise, channels 1..NUM_CH−1 are scanned round-robin starting at rr. The first requester is granted.
  - After a grant to k≥1, rr←k+1, wrapping NUM_CH→1. A channel-0 grant leaves rr unchanged.
- A granted access is applied at the edge closing the ack cycle.
  - Write: each nibble i of the addressed word takes wr_data nibble i iff wr_mask[i]. Other nibbles keep their old value. A mask of 0 means no change.
  - Read: memory is read at the same edge.
- Ungranted requests are not queued internally. The channel holds req, wr, addr and data until ack is seen.
- Banks: bank index = top log2(BANKS) address bits; bank-local address = remaining bits. The bank index of a read is registered and steers the output mux the following cycle. BANKS=1 means a single array with no mux.
- A write returns no data. rd_valid is never set for writes or clear cycles.

## Timing
- ack combinational in cycle c; access at edge c→c+1.
- Read latency 1: rd_valid=1, rd_ch=granted channel and rd_data=word in cycle c+1, for one cycle.
- Back-to-back reads in consecutive cycles give consecutive rd_valid cycles (throughput 1/cycle).
- Write in cycle c followed by a read of the same address in c+1: the read returns the new data (read-after-write coherent).
- Simultaneous events:
  - A req arriving in the first READY cycle is acked that same cycle.
  - A req during CLEAR is ignored, not remembered.
  - reset asserted while a read is in flight: rd_valid=0 next cycle and the data is discarded.
  - reset mid-CLEAR restarts the clear from address 0.
- Address wrap: clr_addr terminates at the max address and does not wrap into a second pass.
- Reset values of outputs: ack=0, rd_valid=0, rd_ch=0, rd_data=0, busy=1.

## Test plan
- Clear (ADDR_W=8, BANKS=4): release reset; busy stays high exactly 1+256 cycles. Then reads of addresses 0x00, 0x3F, 0x40 and 0xFF all return CLEAR_WORD=0xA5A5.
- Priority and round-robin (NUM_CH=3): hold req=3'b111 for 4 cycles → ack=001,001,001,001. Then drop req[0] → ack 010,100,010,100.
- Masked write: write 0x1234 mask 1111 to 0x42, then 0xABCD mask 0101 → a read returns 0x1B3D with rd_ch tagged and rd_valid one cycle after ack.
- Bank boundary and pipelining: pre-write 0x1111 to 0x3F and 0x2222 to 0x40. Consecutive reads of 0x3F, 0x40 and 0x3F produce rd_data 0x1111, 0x2222, 0x1111 in three consecutive valid cycles.
- Read-after-write: write 0xBEEF to 0x10 in cycle c, read 0x10 in cycle c+1 → 0xBEEF in c+2.
- Reset mid-clear: assert reset at clear address 0x80 → clr_addr restarts at 0 and busy is held 257 cycles after release. req asserted during busy gets no ack, and rd_valid stays 0.
